xnode_cfg_array: RTL and testbench

XNODE_CFG_ARRAY -- requirements
Module: xnode_cfg_array

---
 rtl/xnode_cfg_array.sv | 161 ++++++++++++++++
 tb/tb_xnode_cfg_array.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xnode_cfg_array.sv
`default_nettype none
// ============================================================================
//  Module   : xnode_cfg_array
//  Purpose  : V x H crosspoint routing array. Crosspoint (h,v) lives at bit
//             h*V+v of the active register. A new configuration is streamed
//             into a shadow register one CW-bit word at a time, then copied
//             to the active register in a single cycle so routing never
//             changes partially.
//  Revision : 1.0  initial release
// ============================================================================
module xnode_cfg_array #(
  parameter int V       = 8,
  parameter int H       = 4,
  parameter int CW      = 8,
  parameter int REG_OUT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_data,
  output logic          cfg_ready,
  output logic          cfg_done,
  output logic          cfg_busy,
  input  logic [V-1:0]  V_i,
  output logic [V-1:0]  V_o,
  input  logic [H-1:0]  H_i,
  output logic [H-1:0]  H_o
);

  localparam int NB   = V * H;
  localparam int NW   = (NB + CW - 1) / CW;
  localparam int CNTW = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NW - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [1:0]      state_q,  state_d;
  logic [CNTW-1:0] cnt_q,    cnt_d;
  logic [NB-1:0]   shadow_q, shadow_d;
  logic [NB-1:0]   active_q, active_d;

  logic [V-1:0]    route_v;
  logic [H-1:0]    route_h;

  // State, word counter, shadow and active registers; reset clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Next-state: a restart in LOAD takes priority over the final handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (cfg_start) begin
          state_d = ST_LOAD;
        end else if (cfg_valid && (cnt_q == LAST_CNT)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: counter, shadow word write (bits beyond NB dropped), commit copy
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    if ((state_q == ST_IDLE) && cfg_start) begin
      cnt_d = '0;
    end else if (state_q == ST_LOAD) begin
      if (cfg_start) begin
        // Restart: the word on the bus this cycle is dropped, shadow kept as is
        cnt_d = '0;
      end else if (cfg_valid) begin
        for (int k = 0; k < NW; k++) begin
          for (int b = 0; b < CW; b++) begin
            if ((k * CW + b) < NB) begin
              if (cnt_q == CNTW'(k)) shadow_d[k*CW+b] = cfg_data[b];
            end
          end
        end
        cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNTW'(1);
      end
    end
    if (state_q == ST_COMMIT) begin
      active_d = shadow_q;
    end
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    cfg_ready = (state_q == ST_LOAD);
    cfg_done  = (state_q == ST_COMMIT);
    cfg_busy  = (state_q != ST_IDLE);
  end

  // Crosspoint routing uses only the primary inputs, so no loop can form
  always_comb begin
    route_v = V_i;
    route_h = H_i;
    for (int h = 0; h < H; h++) begin
      for (int v = 0; v < V; v++) begin
        route_v[v] = route_v[v] | (active_q[h*V+v] & H_i[h]);
        route_h[h] = route_h[h] | (active_q[h*V+v] & V_i[v]);
      end
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [V-1:0] v_o_q, v_o_d;
      logic [H-1:0] h_o_q, h_o_d;

      assign v_o_d = route_v;
      assign h_o_d = route_h;

      // One-cycle registered routing outputs
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_o_q <= '0;
          h_o_q <= '0;
        end else begin
          v_o_q <= v_o_d;
          h_o_q <= h_o_d;
        end
      end

      assign V_o = v_o_q;
      assign H_o = h_o_q;
    end else begin : g_comb_out
      assign V_o = route_v;
      assign H_o = route_h;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_xnode_cfg_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xnode_cfg_array
//  Purpose  : Directed, table-driven bench for xnode_cfg_array. Two instances
//             share all inputs: one with combinational outputs, one with
//             registered outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xnode_cfg_array;

  logic       clk;
  logic       rst_n;
  logic       cfg_start;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic [7:0] v_i;
  logic [3:0] h_i;

  logic       cfg_ready, cfg_done, cfg_busy;
  logic [7:0] v_o;
  logic [3:0] h_o;

  logic       cfg_ready_r, cfg_done_r, cfg_busy_r;
  logic [7:0] v_o_r;
  logic [3:0] h_o_r;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [31:0] exp_active;

  typedef struct {
    logic [7:0] vi;
    logic [3:0] hi;
    logic [7:0] ev;
    logic [3:0] eh;
  } vec_t;

  vec_t vecs [10];

  xnode_cfg_array #(.V(8), .H(4), .CW(8), .REG_OUT(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_busy  (cfg_busy),
    .V_i       (v_i),
    .V_o       (v_o),
    .H_i       (h_i),
    .H_o       (h_o)
  );

  xnode_cfg_array #(.V(8), .H(4), .CW(8), .REG_OUT(1)) dut_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready_r),
    .cfg_done  (cfg_done_r),
    .cfg_busy  (cfg_busy_r),
    .V_i       (v_i),
    .V_o       (v_o_r),
    .H_i       (h_i),
    .H_o       (h_o_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cfg_done === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference routing for a given active pattern (used for registered-output history)
  function automatic logic [11:0] route(input logic [31:0] act, input logic [7:0] vi,
                                        input logic [3:0] hi);
    logic [7:0] rv;
    logic [3:0] rh;
    rv = vi;
    rh = hi;
    for (int h = 0; h < 4; h++) begin
      for (int v = 0; v < 8; v++) begin
        if (act[h*8+v] && hi[h]) rv[v] = 1'b1;
        if (act[h*8+v] && vi[v]) rh[h] = 1'b1;
      end
    end
    return {rh, rv};
  endfunction

  task automatic run_table(input int lo, input int hi);
    logic [11:0] prev;
    @(negedge clk);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      prev = route(exp_active, v_i, h_i);
      v_i = vecs[i].vi;
      h_i = vecs[i].hi;
      #1;
      chk($sformatf("vec%0d V_o", i), v_o, vecs[i].ev);
      chk($sformatf("vec%0d H_o", i), h_o, vecs[i].eh);
      chk($sformatf("vec%0d V_o_r before edge", i), v_o_r, prev[7:0]);
      chk($sformatf("vec%0d H_o_r before edge", i), h_o_r, prev[11:8]);
      @(negedge clk);
      chk($sformatf("vec%0d V_o_r after edge", i), v_o_r, vecs[i].ev);
      chk($sformatf("vec%0d H_o_r after edge", i), h_o_r, vecs[i].eh);
    end
  endtask

  // Already in LOAD with cfg_start low: stream four words, then check the commit
  task automatic feed_words(input string nm, input logic [31:0] words);
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = words[i*8 +: 8];
      #1;
      chk($sformatf("%s ready w%0d", nm, i), cfg_ready, 1);
      chk($sformatf("%s done low w%0d", nm, i), cfg_done, 0);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    chk({nm, " done pulse"}, cfg_done, 1);
    chk({nm, " ready low in commit"}, cfg_ready, 0);
    chk({nm, " active held in commit"}, dut.active_q, exp_active);
    @(negedge clk);
    chk({nm, " done cleared"}, cfg_done, 0);
    chk({nm, " busy cleared"}, cfg_busy, 0);
    chk({nm, " active"}, dut.active_q, words);
    exp_active = words;
  endtask

  task automatic load4(input string nm, input logic [31:0] words, input logic valid_on_start);
    @(negedge clk);
    cfg_start = 1'b1;
    cfg_valid = valid_on_start;
    cfg_data  = 8'hFF;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    chk({nm, " busy"}, cfg_busy, 1);
    feed_words(nm, words);
  endtask

  initial begin
    int done_before;

    vecs[0] = '{8'hFF, 4'h0, 8'hFF, 4'h0};
    vecs[1] = '{8'h00, 4'hF, 8'h00, 4'hF};
    vecs[2] = '{8'hA5, 4'h3, 8'hA5, 4'h3};
    vecs[3] = '{8'hFF, 4'h0, 8'hFF, 4'hF};
    vecs[4] = '{8'h00, 4'h4, 8'h04, 4'h4};
    vecs[5] = '{8'h08, 4'h0, 8'h08, 4'h8};
    vecs[6] = '{8'h00, 4'h1, 8'h01, 4'h1};
    vecs[7] = '{8'h01, 4'h0, 8'h01, 4'hF};
    vecs[8] = '{8'h00, 4'h1, 8'hFF, 4'h1};
    vecs[9] = '{8'h00, 4'h0, 8'h00, 4'h0};

    exp_active = 32'h0;
    rst_n      = 1'b0;
    cfg_start  = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = 8'h00;
    v_i        = 8'hFF;
    h_i        = 4'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset ready", cfg_ready, 0);
    chk("reset done", cfg_done, 0);
    chk("reset busy", cfg_busy, 0);
    chk("reset active", dut.active_q, 32'h0);
    chk("reset V_o passthrough", v_o, 8'hFF);
    chk("reset V_o_r forced", v_o_r, 8'h00);
    rst_n = 1'b1;

    // Pass-through with empty configuration
    run_table(0, 2);

    // cfg_valid alone in IDLE is ignored
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("idle valid busy", cfg_busy, 0);
    chk("idle valid active", dut.active_q, 32'h0);

    // Diagonal load
    load4("load1", 32'h08040201, 1'b0);
    run_table(3, 6);

    // Gapped load keeps old routing, then restart with a handshake on the same cycle
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = 8'hFF;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    v_i = 8'h00;
    h_i = 4'h1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("gap busy c%0d", i), cfg_busy, 1);
      chk($sformatf("gap V_o old cfg c%0d", i), v_o, 8'h01);
      chk($sformatf("gap H_o old cfg c%0d", i), h_o, 4'h1);
      @(negedge clk);
    end
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 8'h00;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("restart active held", dut.active_q, 32'h08040201);
    feed_words("reload", 32'hFFFFFFFF);
    run_table(7, 8);

    // Reset in the middle of a load
    done_before = done_cnt;
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = 8'h11 * (i + 1);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset active", dut.active_q, 32'h0);
    chk("midreset busy", cfg_busy, 0);
    chk("midreset ready", cfg_ready, 0);
    exp_active = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset no done", done_cnt, done_before);
    v_i = 8'hFF;
    h_i = 4'h0;
    #1;
    chk("midreset passthrough H_o", h_o, 4'h0);

    // Start and valid together in IDLE: the word is not stored
    load4("load3", 32'h08040201, 1'b1);
    run_table(3, 6);
    run_table(9, 9);

    chk("total done pulses", done_cnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
